sequenciador_movimentos_rx: RTL and testbench
=============================================

Name: sequenciador_movimentos_rx

Overview:
Controller that sits behind the 8N1 serial receiver in recebe_movimentos. It collects the received bytes into a movement sequence and validates each byte. The sequence ends when the terminator byte arrives, or the controller aborts it on a timeout or an error. A completed sequence is buffered in an internal FIFO and handed to the movement executor through a valid/next handshake.

Parameters:
DEPTH, 32, FIFO capacity in movement bytes (power of 2, >=2)
TERM, 8'h0A, sequence terminator byte
TIMEOUT, 50_000_000, maximum clock cycles allowed between consecutive bytes of one sequence
ACK, 8'h06, byte echoed when a sequence completes (ECO_EN only)
NAK, 8'h15, byte echoed on an error (ECO_EN only)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_pronto  input  1  one-cycle pulse from the receiver: rx_dado is valid
rx_dado  input  8  received byte
proximo  input  1  executor consumes the current movimento
limpa  input  1  clears the ERRO state
movimento  output  8  FIFO head byte
mov_valido  output  1  movimento is valid; only asserted in COMPLETO
qtd  output  $clog2(DEPTH)+1  bytes currently stored
recebendo  output  1  high in RECEBE
fim_sequencia  output  1  one-cycle pulse after the last movement is consumed
erro  output  1  high in ERRO
db_estado  output  4  debug state code
tx_partida  output  1  ECO_EN only: one-cycle transmit request
tx_dado  output  8  ECO_EN only: byte to transmit

Behaviour:
- Single clock domain; all state and outputs are updated on posedge clock.
- reset=1 at an edge (including mid-sequence): state OCIOSO, FIFO flushed (qtd=0), timeout counter=0. All pulse and flag outputs go to 0, movimento=0, tx_dado=0.
- Legal movement bytes: 'U' 55, 'D' 44, 'L' 4C, 'R' 52, 'F' 46, 'B' 42, apostrophe 27 (prime), '2' 32.
- States and db_estado codes: OCIOSO=0, RECEBE=1, COMPLETO=3, FINAL=7, ERRO=E. Any unused encoding returns to OCIOSO.
- OCIOSO:
  - rx_pronto with a legal byte: write the byte, qtd=1, go to RECEBE.
  - TERM or any illegal byte: discarded, stay in OCIOSO (an empty sequence is ignored).
- RECEBE: timeout counter increments every cycle and is cleared to 0 on each accepted rx_pronto.
  - Legal byte with qtd<DEPTH: written; qtd increments the next cycle.
  - Legal byte with qtd==DEPTH (overflow): go to ERRO.
  - TERM: go to COMPLETO; the terminator is not stored.
  - Illegal byte: go to ERRO.
  - Counter reaches TIMEOUT-1 with no rx_pronto: go to ERRO.
  - rx_pronto in the same cycle as the timeout expiry: the byte wins and the counter clears.
- COMPLETO:
  - mov_valido=1 and movimento shows the FIFO head combinationally from the registered read pointer.
  - proximo with mov_valido: pops; the new head is visible the next cycle.
  - proximo while mov_valido=0 is ignored.
  - rx_pronto is ignored; bytes are dropped, no error.
  - Popping the entry when qtd==1: go to FINAL.
- FINAL: fim_sequencia=1 for exactly one cycle, then OCIOSO.
- ERRO:
  - FIFO is flushed on entry (qtd=0 the cycle after entry); erro=1.
  - rx_pronto is ignored.
  - limpa: go to OCIOSO next cycle.
  - reset takes priority over limpa.
- FIFO: circular buffer with rd/wr pointers of width $clog2(DEPTH) wrapping modulo DEPTH. qtd is tracked separately. No simultaneous push and pop occurs, since pushes happen only in OCIOSO/RECEBE and pops only in COMPLETO.
- Latency: rx_pronto to qtd update is 1 cycle; rx_pronto(TERM) to mov_valido=1 is 1 cycle.

Optional Feature:
Macro SEQUENCIADOR_ECO_EN.
- Defined:
  - On the transition into COMPLETO: tx_partida pulses 1 cycle with tx_dado=ACK.
  - On any transition into ERRO: tx_partida pulses 1 cycle with tx_dado=NAK.
  - tx_dado holds its value until the next pulse.
- Undefined: tx_partida and tx_dado are tied to 0 and no echo logic is synthesized.

Test Plan:
1. Reset, then send 'R','U','2',0x0A as rx_pronto pulses 10 cycles apart.
   - qtd steps 1,2,3; mov_valido=1 with movimento=52.
   - Pulse proximo 3 times: movimento reads 55 then 32.
   - fim_sequencia pulses once, then db_estado=0.
2. Send 'F', then wait TIMEOUT cycles with no byte (use TIMEOUT=100 in the bench).
   - erro=1, db_estado=E, qtd=0.
   - limpa returns the block to OCIOSO.
3. With DEPTH=4, send 5 'L' bytes.
   - ERRO on the 5th byte; the FIFO is flushed.
   - With ECO_EN: tx_partida with tx_dado=15.
4. Send 'D', then 0x41 ('A').
   - ERRO.
   - 0x0A or 0x41 received in OCIOSO: ignored, db_estado stays 0.
5. In COMPLETO holding 2 entries, inject rx_pronto 'B'.
   - Ignored, qtd stays 2.
   - proximo while in OCIOSO: no effect.
6. Assert reset mid-RECEBE with qtd=3.
   - Next cycle: qtd=0, db_estado=0, all outputs 0.
   - A following 'U',0x0A sequence works normally; with ECO_EN, ACK (06) is echoed.

Source files
------------

// File: rtl/sequenciador_movimentos_rx.sv
// Sequence controller behind the 8N1 receiver: validates movement bytes, buffers a
// terminated sequence in a FIFO and hands it out via valid/next. Optional echo: SEQUENCIADOR_ECO_EN.
module sequenciador_movimentos_rx #(
  parameter int unsigned DEPTH   = 32,
  parameter logic [7:0]  TERM    = 8'h0A,
  parameter int unsigned TIMEOUT = 50_000_000,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_pronto,
  input  logic [7:0]               rx_dado,
  input  logic                     proximo,
  input  logic                     limpa,
  output logic [7:0]               movimento,
  output logic                     mov_valido,
  output logic [$clog2(DEPTH):0]   qtd,
  output logic                     recebendo,
  output logic                     fim_sequencia,
  output logic                     erro,
  output logic [3:0]               db_estado,
  output logic                     tx_partida,
  output logic [7:0]               tx_dado
);

  // state    | meaning
  // OCIOSO   | idle, waiting for the first legal byte
  // RECEBE   | collecting bytes, inter-byte timeout running
  // COMPLETO | sequence terminated, FIFO head offered to executor
  // FINAL    | last entry consumed, one-cycle end pulse
  // ERRO     | aborted, FIFO flushed, waiting for limpa
  typedef enum logic [3:0] {
    OCIOSO   = 4'h0,
    RECEBE   = 4'h1,
    COMPLETO = 4'h3,
    FINAL    = 4'h7,
    ERRO     = 4'hE
  } estado_t;

  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);

  estado_t         state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [QW-1:0]   qtd_q;
  logic [CW-1:0]   cnt_q;
  logic            push, pop, flush;

  function automatic logic legal(input logic [7:0] b);
    case (b)
      8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42, 8'h27, 8'h32: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (rx_pronto && legal(rx_dado)) begin
          push    = 1'b1;
          state_d = RECEBE;
        end
      end
      RECEBE: begin
        if (rx_pronto) begin
          if (rx_dado == TERM)          state_d = COMPLETO;
          else if (!legal(rx_dado))     state_d = ERRO;
          else if (qtd_q == QW'(DEPTH)) state_d = ERRO;
          else                          push    = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERRO;
        end
      end
      COMPLETO: begin
        if (proximo) begin
          pop = 1'b1;
          if (qtd_q == QW'(1)) state_d = FINAL;
        end
      end
      FINAL:   state_d = OCIOSO;
      ERRO:    if (limpa) state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    movimento     = '0;
    mov_valido    = 1'b0;
    recebendo     = 1'b0;
    fim_sequencia = 1'b0;
    erro          = 1'b0;
    case (state_q)
      RECEBE:   recebendo = 1'b1;
      COMPLETO: begin
        mov_valido = 1'b1;
        movimento  = mem_q[rd_q];
      end
      FINAL:    fim_sequencia = 1'b1;
      ERRO:     erro = 1'b1;
      default:  ;
    endcase
  end

  assign db_estado = state_q;
  assign qtd       = qtd_q;
  assign flush     = (state_d == ERRO);

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= rx_dado;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      qtd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        qtd_q <= '0;
      end else if (push) begin
        wr_q  <= wr_q + 1'b1;
        qtd_q <= qtd_q + 1'b1;
      end else if (pop) begin
        rd_q  <= rd_q + 1'b1;
        qtd_q <= qtd_q - 1'b1;
      end
      // a byte arriving on the expiry cycle clears the count instead of aborting
      if (state_q == RECEBE && !rx_pronto) cnt_q <= cnt_q + 1'b1;
      else                                 cnt_q <= '0;
    end
  end

`ifdef SEQUENCIADOR_ECO_EN
  logic       tx_partida_q;
  logic [7:0] tx_dado_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_partida_q <= 1'b0;
      tx_dado_q    <= '0;
    end else begin
      tx_partida_q <= 1'b0;
      if (state_d != state_q && state_d == COMPLETO) begin
        tx_partida_q <= 1'b1;
        tx_dado_q    <= ACK;
      end else if (state_d != state_q && state_d == ERRO) begin
        tx_partida_q <= 1'b1;
        tx_dado_q    <= NAK;
      end
    end
  end

  assign tx_partida = tx_partida_q;
  assign tx_dado    = tx_dado_q;
`else
  logic unused_eco;
  assign unused_eco = ^{ACK, NAK};
  assign tx_partida = 1'b0;
  assign tx_dado    = '0;
`endif

endmodule

// File: tb/tb_sequenciador_movimentos_rx.sv
// Bench for sequenciador_movimentos_rx: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a queue-based sequence model.
module tb_sequenciador_movimentos_rx;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam logic [7:0]  TERM    = 8'h0A;
  localparam logic [7:0]  ACK     = 8'h06;
  localparam logic [7:0]  NAK     = 8'h15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pronto = 1'b0;
  logic [7:0] rx_dado = 8'h00;
  logic proximo = 1'b0;
  logic limpa = 1'b0;
  logic [7:0] movimento;
  logic mov_valido;
  logic [$clog2(DEPTH):0] qtd;
  logic recebendo, fim_sequencia, erro;
  logic [3:0] db_estado;
  logic tx_partida;
  logic [7:0] tx_dado;

  sequenciador_movimentos_rx #(
    .DEPTH(DEPTH), .TERM(TERM), .TIMEOUT(TIMEOUT), .ACK(ACK), .NAK(NAK)
  ) dut (
    .clock(clk), .reset(rst), .rx_pronto(rx_pronto), .rx_dado(rx_dado),
    .proximo(proximo), .limpa(limpa), .movimento(movimento), .mov_valido(mov_valido),
    .qtd(qtd), .recebendo(recebendo), .fim_sequencia(fim_sequencia), .erro(erro),
    .db_estado(db_estado), .tx_partida(tx_partida), .tx_dado(tx_dado)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] legal_tab [8] = '{8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42, 8'h27, 8'h32};

  function automatic bit is_legal(input logic [7:0] b);
    foreach (legal_tab[i]) if (legal_tab[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Model: mode holds the expected debug code; the sequence is a plain queue.
  int         m_mode = 0;
  int         m_next;
  int         m_idle = 0;
  logic [7:0] m_q [$];
  logic       m_txp = 1'b0;
  logic [7:0] m_txd = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_q.delete(); m_idle = 0; m_txp = 1'b0; m_txd = 8'h00;
    end else begin
      m_next = m_mode;
      m_txp  = 1'b0;
      case (m_mode)
        0: if (rx_pronto && is_legal(rx_dado)) begin
             m_q.push_back(rx_dado); m_idle = 0; m_next = 1;
           end
        1: if (rx_pronto) begin
             m_idle = 0;
             if (rx_dado == TERM) m_next = 3;
             else if (!is_legal(rx_dado) || m_q.size() == DEPTH) m_next = 14;
             else m_q.push_back(rx_dado);
           end else begin
             m_idle++;
             if (m_idle >= TIMEOUT) m_next = 14;
           end
        3: if (proximo) begin
             void'(m_q.pop_front());
             if (m_q.size() == 0) m_next = 7;
           end
        7: m_next = 0;
        14: if (limpa) m_next = 0;
        default: m_next = 0;
      endcase
      if (m_next == 14 && m_mode != 14) begin
        m_q.delete(); m_txp = 1'b1; m_txd = NAK;
      end
      if (m_next == 3 && m_mode != 3) begin
        m_txp = 1'b1; m_txd = ACK;
      end
      m_mode = m_next;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("db_estado", 32'(db_estado), 32'(m_mode));
      check("qtd", 32'(qtd), 32'(m_q.size()));
      check("mov_valido", 32'(mov_valido), 32'(m_mode == 3));
      check("movimento", 32'(movimento), (m_mode == 3 && m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
      check("recebendo", 32'(recebendo), 32'(m_mode == 1));
      check("fim_sequencia", 32'(fim_sequencia), 32'(m_mode == 7));
      check("erro", 32'(erro), 32'(m_mode == 14));
`ifdef SEQUENCIADOR_ECO_EN
      check("tx_partida", 32'(tx_partida), 32'(m_txp));
      check("tx_dado", 32'(tx_dado), 32'(m_txd));
`else
      check("tx_partida", 32'(tx_partida), 32'd0);
      check("tx_dado", 32'(tx_dado), 32'd0);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_pronto = 1'b1; rx_dado = b;
    @(negedge clk); rx_pronto = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk); proximo = 1'b1;
    @(negedge clk); proximo = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk); limpa = 1'b1;
    @(negedge clk); limpa = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int r;
  int phase;

  initial begin
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_db", 32'(db_estado), 32'h0);
    check("reset_qtd", 32'(qtd), 32'd0);

    // 1: R U 2 TERM, then three pops
    send(8'h52); check("t1_qtd1", 32'(qtd), 32'd1); check("t1_rx", 32'(recebendo), 32'd1);
    cyc(8); send(8'h55); check("t1_qtd2", 32'(qtd), 32'd2);
    cyc(8); send(8'h32); check("t1_qtd3", 32'(qtd), 32'd3);
    cyc(8); send(TERM);
    check("t1_valid", 32'(mov_valido), 32'd1);
    check("t1_mov0", 32'(movimento), 32'h52);
    check("t1_db3", 32'(db_estado), 32'h3);
    pop_one(); check("t1_mov1", 32'(movimento), 32'h55);
    pop_one(); check("t1_mov2", 32'(movimento), 32'h32);
    pop_one(); check("t1_fim", 32'(fim_sequencia), 32'd1); check("t1_db7", 32'(db_estado), 32'h7);
    cyc(1); check("t1_fim_off", 32'(fim_sequencia), 32'd0); check("t1_db0", 32'(db_estado), 32'h0);

    // 2: timeout boundary, then byte arriving exactly on the expiry cycle
    send(8'h46);
    cyc(TIMEOUT - 1); check("t2_not_yet", 32'(erro), 32'd0);
    cyc(1); check("t2_erro", 32'(erro), 32'd1); check("t2_dbE", 32'(db_estado), 32'hE);
    check("t2_qtd0", 32'(qtd), 32'd0);
    clear_err(); check("t2_clr", 32'(db_estado), 32'h0);
    send(8'h46); cyc(TIMEOUT - 2); send(8'h55);
    check("t2_byte_wins", 32'(erro), 32'd0); check("t2_qtd2", 32'(qtd), 32'd2);
    cyc(TIMEOUT + 2); check("t2_erro2", 32'(erro), 32'd1);
    clear_err();

    // 3: overflow
    repeat (4) send(8'h4C);
    check("t3_full", 32'(qtd), 32'd4);
    send(8'h4C);
    check("t3_erro", 32'(erro), 32'd1); check("t3_flush", 32'(qtd), 32'd0);
`ifdef SEQUENCIADOR_ECO_EN
    check("t3_txp", 32'(tx_partida), 32'd1); check("t3_nak", 32'(tx_dado), 32'h15);
`endif
    clear_err();

    // 4: illegal byte mid-sequence, then junk in OCIOSO
    send(8'h44); send(8'h41); check("t4_erro", 32'(erro), 32'd1);
    clear_err();
    send(TERM); check("t4_term_idle", 32'(db_estado), 32'h0);
    send(8'h41); check("t4_ill_idle", 32'(db_estado), 32'h0); check("t4_qtd", 32'(qtd), 32'd0);

    // 5: rx ignored in COMPLETO, proximo ignored in OCIOSO
    send(8'h55); send(8'h44); send(TERM);
    check("t5_qtd2", 32'(qtd), 32'd2);
    send(8'h42); check("t5_ign", 32'(qtd), 32'd2); check("t5_db3", 32'(db_estado), 32'h3);
    pop_one(); pop_one(); cyc(1);
    pop_one(); check("t5_prox_idle", 32'(db_estado), 32'h0); check("t5_qtd0", 32'(qtd), 32'd0);

    // 6: reset mid-RECEBE
    send(8'h55); send(8'h52); send(8'h46);
    check("t6_qtd3", 32'(qtd), 32'd3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_qtd", 32'(qtd), 32'd0); check("t6_db", 32'(db_estado), 32'h0);
    check("t6_rx", 32'(recebendo), 32'd0); check("t6_mov", 32'(movimento), 32'd0);
    check("t6_txp", 32'(tx_partida), 32'd0); check("t6_txd", 32'(tx_dado), 32'd0);
    send(8'h55); send(TERM);
    check("t6_valid", 32'(mov_valido), 32'd1); check("t6_mov55", 32'(movimento), 32'h55);
`ifdef SEQUENCIADOR_ECO_EN
    check("t6_txp_ack", 32'(tx_partida), 32'd1); check("t6_ack", 32'(tx_dado), 32'h06);
`endif
    pop_one(); cyc(2);

    // randomized phase
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      phase = (i / 250) % 3;
      case (phase)
        0: rx_pronto = ($urandom_range(0, 2) == 0);
        1: rx_pronto = ($urandom_range(0, 19) == 0);
        default: rx_pronto = ($urandom_range(0, 199) == 0);
      endcase
      r = int'($urandom_range(0, 9));
      if (r < 6)       rx_dado = legal_tab[$urandom_range(0, 7)];
      else if (r < 8)  rx_dado = TERM;
      else             rx_dado = 8'($urandom);
      proximo = ($urandom_range(0, 2) == 0);
      limpa   = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    rx_pronto = 1'b0; proximo = 1'b0; limpa = 1'b0; rst = 1'b0;
    cyc(3);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
